cpu_control_rtype: RTL and testbench

//  Single-cycle MIPS datapath that executes only R-type instructions. Top-level CPU core.
//  Per clock: fetch from instruction memory, read two registers, perform the ALU op,

---
 rtl/cpu_control_rtype.sv | 154 +++++++++++++++
 tb/tb_cpu_control_rtype.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cpu_control_rtype.sv
// Single-cycle R-type-only MIPS core.
// Each cycle the core fetches the word at PC, reads rs/rt, runs the ALU and
// writes the result to rd on the same rising edge that advances PC.
// IM.instBank and BR.registerBank are loaded from outside; the core never
// initialises them.

// Byte-wide instruction ROM with an asynchronous, big-endian word fetch.
module cpu_inst_mem #(
    parameter int IMEM_BYTES = 256
) (
    input  logic [$clog2(IMEM_BYTES)-3:0] i_word,
    output logic [31:0]                   o_inst
);
    logic [7:0] instBank [0:IMEM_BYTES-1];

    // The word index plus a byte lane gives each byte address directly, so no adder is needed.
    always_comb begin
        o_inst = {instBank[{i_word, 2'b00}], instBank[{i_word, 2'b01}],
                  instBank[{i_word, 2'b10}], instBank[{i_word, 2'b11}]};
    end
endmodule

// Register file: two asynchronous read ports and one synchronous write port. $0 is hard zero.
module cpu_reg_bank #(
    parameter int NREGS = 32
) (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] registerBank [0:NREGS-1];

    // Write port. Writes to $0 are dropped, and nothing is bypassed to the read ports.
    // NOTE: storage arrays get no reset. That keeps preloaded contents across a
    // reset and lets the array map onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_we && (i_wa != 5'd0)) begin
            registerBank[i_wa] <= i_wd;
        end
    end

    // Read ports. $0 reads as zero whatever is stored in entry 0.
    always_comb begin
        o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : registerBank[i_ra1];
        o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : registerBank[i_ra2];
    end
endmodule

// Top level: PC register, decode, ALU control and write-back.
module cpu_control_rtype #(
    parameter int IMEM_BYTES = 256,
    parameter int NREGS      = 32
) (
    input  logic        clk_CPU,
    input  logic        rst_CPU,
    output logic [31:0] resultado
);
    localparam int AW = $clog2(IMEM_BYTES);

    typedef enum logic [5:0] {
        F_SLL = 6'h00,
        F_SRL = 6'h02,
        F_ADD = 6'h20,
        F_SUB = 6'h22,
        F_AND = 6'h24,
        F_OR  = 6'h25,
        F_XOR = 6'h26,
        F_NOR = 6'h27,
        F_SLT = 6'h2A
    } funct_e;

    logic [31:0] r_pc;
    logic [31:0] w_inst;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic        w_reg_write;
    logic [AW-3:0] w_word;
    logic [AW+1:0] w_unused_pc;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [4:0] w_shamt;
    logic [5:0] w_funct;

    // Fetch wraps naturally because only the in-range word index of PC is used.
    assign w_word      = r_pc[AW-1:2];
    assign w_unused_pc = {r_pc[31:AW], r_pc[1:0]};

    // PC advances one word per cycle. Reset clears it immediately, without waiting for a clock edge.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_CPU or posedge rst_CPU) begin
        if (rst_CPU) begin
            r_pc <= 32'd0;
        end else begin
            r_pc <= r_pc + 32'd4;
        end
    end

    cpu_inst_mem #(.IMEM_BYTES(IMEM_BYTES)) IM (
        .i_word (w_word),
        .o_inst (w_inst)
    );

    assign w_op    = w_inst[31:26];
    assign w_rs    = w_inst[25:21];
    assign w_rt    = w_inst[20:16];
    assign w_rd    = w_inst[15:11];
    assign w_shamt = w_inst[10:6];
    assign w_funct = w_inst[5:0];

    // A write is blocked if reset is high at the edge, which drops the pending result.
    cpu_reg_bank #(.NREGS(NREGS)) BR (
        .i_clk (clk_CPU),
        .i_we  (w_reg_write && !rst_CPU),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .i_wa  (w_rd),
        .i_wd  (w_alu),
        .o_rd1 (w_a),
        .o_rd2 (w_b)
    );

    // ALU control and ALU. Any instruction that is not a supported R-type yields 0 and no write.
    // NOTE: both outputs get defaults first, so no path leaves them unassigned and no latch is inferred.
    always_comb begin
        w_alu       = 32'd0;
        w_reg_write = 1'b0;
        if (w_op == 6'd0) begin
            w_reg_write = 1'b1;
            case (w_funct)
                F_ADD:   w_alu = w_a + w_b;
                F_SUB:   w_alu = w_a - w_b;
                F_AND:   w_alu = w_a & w_b;
                F_OR:    w_alu = w_a | w_b;
                F_XOR:   w_alu = w_a ^ w_b;
                F_NOR:   w_alu = ~(w_a | w_b);
                F_SLT:   w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
                F_SLL:   w_alu = w_b << w_shamt;
                F_SRL:   w_alu = w_b >> w_shamt;
                default: w_reg_write = 1'b0;
            endcase
        end
    end

    assign resultado = w_alu;
endmodule

// File: tb/tb_cpu_control_rtype.sv
// Bench for cpu_control_rtype. It runs a directed program followed by random
// instructions, and a reference model written from the instruction semantics
// predicts every result, PC value and register.
module tb_cpu_control_rtype;
    logic        clk_CPU;
    logic        rst_CPU;
    logic [31:0] resultado;

    int vectors;
    int miscompares;

    logic [31:0] m_regs [32];
    logic [31:0] m_imem [64];
    logic [31:0] m_pc;

    logic [31:0] dir_exp [16] = '{
        32'h0000_0008, 32'hFFFF_FFFE, 32'h0000_0001, 32'h000F_000F,
        32'h0FFF_0FFF, 32'hF000_F000, 32'h0000_0008, 32'h0000_0010,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0050, 32'h0FFF_FFFF,
        32'h0FF0_0FF0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFF8
    };

    logic [5:0] funct_pool [11] = '{
        6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h3F, 6'h21
    };

    cpu_control_rtype dut (
        .clk_CPU   (clk_CPU),
        .rst_CPU   (rst_CPU),
        .resultado (resultado)
    );

    initial clk_CPU = 1'b0;
    always #5 clk_CPU = ~clk_CPU;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ins_r(input logic [5:0] f, input int rd, input int rs,
                                          input int rt, input int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), f};
    endfunction

    // Reference semantics: returns {writes_rd, result} for an instruction against the model registers.
    function automatic logic [32:0] ref_exec(input logic [31:0] inst);
        logic [31:0] a;
        logic [31:0] b;
        int sh;
        a  = (inst[25:21] == 5'd0) ? 32'd0 : m_regs[inst[25:21]];
        b  = (inst[20:16] == 5'd0) ? 32'd0 : m_regs[inst[20:16]];
        sh = int'(inst[10:6]);
        if (inst[31:26] != 6'd0) return 33'd0;
        case (inst[5:0])
            6'h20:   return {1'b1, a + b};
            6'h22:   return {1'b1, a - b};
            6'h24:   return {1'b1, a & b};
            6'h25:   return {1'b1, a | b};
            6'h26:   return {1'b1, a ^ b};
            6'h27:   return {1'b1, ~(a | b)};
            6'h2A:   return {1'b1, (int'(a) < int'(b)) ? 32'd1 : 32'd0};
            6'h00:   return {1'b1, b << sh};
            6'h02:   return {1'b1, b >> sh};
            default: return 33'd0;
        endcase
    endfunction

    // One instruction: check the result before the edge, then the PC after it.
    task automatic step(input string tag);
        logic [32:0] r;
        logic [31:0] inst;
        inst = m_imem[m_pc[7:2]];
        r    = ref_exec(inst);
        check(tag, resultado, r[31:0]);
        @(posedge clk_CPU);
        if (r[32] && inst[15:11] != 5'd0) m_regs[inst[15:11]] = r[31:0];
        m_pc = m_pc + 32'd4;
        @(negedge clk_CPU);
        check("pc", dut.r_pc, m_pc);
    endtask

    initial begin
        logic [32:0] r;
        logic [31:0] w;
        logic [5:0]  op;
        vectors     = 0;
        miscompares = 0;
        rst_CPU     = 1'b0;
        #1 rst_CPU  = 1'b1;

        for (int i = 0; i < 32; i++) m_regs[i] = $urandom;
        m_regs[0] = 32'hDEAD_BEEF;
        m_regs[1] = 32'd5;
        m_regs[2] = 32'd3;
        m_regs[8] = 32'h0F0F_0F0F;
        m_regs[9] = 32'h00FF_00FF;
        for (int i = 0; i < 32; i++) dut.BR.registerBank[i] = m_regs[i];

        m_imem[0]  = ins_r(6'h20, 3, 1, 2, 0);
        m_imem[1]  = ins_r(6'h22, 4, 2, 1, 0);
        m_imem[2]  = ins_r(6'h2A, 5, 4, 1, 0);
        m_imem[3]  = ins_r(6'h24, 10, 8, 9, 0);
        m_imem[4]  = ins_r(6'h25, 11, 8, 9, 0);
        m_imem[5]  = ins_r(6'h27, 12, 8, 9, 0);
        m_imem[6]  = ins_r(6'h20, 0, 1, 2, 0);
        m_imem[7]  = ins_r(6'h20, 6, 3, 3, 0);
        m_imem[8]  = {6'h08, 5'd1, 5'd2, 16'h1800};
        m_imem[9]  = ins_r(6'h3F, 13, 1, 2, 0);
        m_imem[10] = ins_r(6'h00, 7, 0, 1, 4);
        m_imem[11] = ins_r(6'h02, 13, 0, 4, 4);
        m_imem[12] = ins_r(6'h26, 14, 8, 9, 0);
        m_imem[13] = ins_r(6'h25, 15, 0, 1, 0);
        m_imem[14] = ins_r(6'h2A, 16, 1, 4, 0);
        m_imem[15] = ins_r(6'h22, 17, 3, 6, 0);
        for (int i = 16; i < 64; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            m_imem[i] = {op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                         funct_pool[$urandom_range(0, 10)]};
        end
        for (int i = 0; i < 64; i++) begin
            w = m_imem[i];
            dut.IM.instBank[4*i]   = w[31:24];
            dut.IM.instBank[4*i+1] = w[23:16];
            dut.IM.instBank[4*i+2] = w[15:8];
            dut.IM.instBank[4*i+3] = w[7:0];
        end

        #1 check("reset_pc", dut.r_pc, 32'd0);
        @(negedge clk_CPU);
        rst_CPU = 1'b0;
        m_pc    = 32'd0;

        // Directed program, checked against hand-derived constants and the model.
        for (int i = 0; i < 16; i++) begin
            check($sformatf("dir%0d", i), resultado, dir_exp[i]);
            step("model_dir");
            if (i == 0) check("r3_after_add", dut.BR.registerBank[3], 32'd8);
            if (i == 7) check("r6_dependent", dut.BR.registerBank[6], 32'd16);
        end
        check("r0_raw_untouched", dut.BR.registerBank[0], 32'hDEAD_BEEF);
        check("r7_sll", dut.BR.registerBank[7], 32'h0000_0050);

        // Random section, running long enough to wrap past the end of the instruction memory.
        for (int i = 0; i < 120; i++) step("model_rand");

        // Reset raised between clock edges: PC clears at once and the pending write is dropped.
        #2 rst_CPU = 1'b1;
        m_pc = 32'd0;
        #1 check("async_reset_pc", dut.r_pc, 32'd0);
        r = ref_exec(m_imem[0]);
        check("reset_result", resultado, r[31:0]);
        @(posedge clk_CPU);
        @(negedge clk_CPU);
        check("reset_hold_pc", dut.r_pc, 32'd0);
        for (int i = 0; i < 32; i++) check($sformatf("reg_in_reset%0d", i), dut.BR.registerBank[i], m_regs[i]);
        rst_CPU = 1'b0;

        for (int i = 0; i < 20; i++) step("model_restart");

        for (int i = 0; i < 32; i++) check($sformatf("reg_final%0d", i), dut.BR.registerBank[i], m_regs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
